// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: sequences address, receive and transmit phases
// from bit-level strobes and drives the FIFO/shift-register controls and SDA select.
module i2c_slave_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_found,
  input  logic             stop_found,
  input  logic             address_match,
  input  logic             rw_mode,
  input  logic             byte_received,
  input  logic             ack_prep,
  input  logic             check_ack,
  input  logic             ack_done,
  input  logic             sda_in,
  input  logic             rx_fifo_full,
  input  logic             tx_fifo_empty,
  output logic             rx_enable,
  output logic             write_enable,
  output logic             read_enable,
  output logic             load_data,
  output logic [1:0]       sda_mode,
  output logic             tx_underrun,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_CHK_ADDR  = 4'd2;
  localparam logic [3:0] S_ADDR_ACK  = 4'd3;
  localparam logic [3:0] S_ADDR_NACK = 4'd4;
  localparam logic [3:0] S_RX_DATA   = 4'd5;
  localparam logic [3:0] S_RX_PUSH   = 4'd6;
  localparam logic [3:0] S_RX_ACK    = 4'd7;
  localparam logic [3:0] S_RX_NACK   = 4'd8;
  localparam logic [3:0] S_TX_LOAD   = 4'd9;
  localparam logic [3:0] S_TX_DATA   = 4'd10;
  localparam logic [3:0] S_TX_CHK    = 4'd11;
  localparam logic [3:0] S_TX_WAIT   = 4'd12;
  localparam logic [3:0] S_WAIT_STOP = 4'd13;

  // Handshake: every input strobe is a one-cycle pulse acted on at the clk edge
  // where it is high; every output is registered and reflects that edge's decision.
  logic [3:0]       state, state_nxt;
  logic [1:0]       sda_nxt;
  logic             we_nxt, re_nxt, ld_nxt, un_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    sda_nxt   = sda_mode;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    ld_nxt    = 1'b0;
    un_nxt    = 1'b0;
    cnt_nxt   = byte_count;
    if (stop_found) begin
      state_nxt = S_IDLE;
    end else if (start_found) begin
      state_nxt = S_ADDR;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_ADDR: if (byte_received) state_nxt = S_CHK_ADDR;
        S_CHK_ADDR: state_nxt = address_match ? S_ADDR_ACK : S_ADDR_NACK;
        S_ADDR_ACK: begin
          if (ack_done)      state_nxt = rw_mode ? S_TX_LOAD : S_RX_DATA;
          else if (ack_prep) sda_nxt   = 2'd1;
        end
        S_ADDR_NACK: if (ack_done) state_nxt = S_WAIT_STOP;
        S_RX_DATA: if (byte_received) state_nxt = S_RX_PUSH;
        S_RX_PUSH: begin
          if (!rx_fifo_full) begin
            we_nxt    = 1'b1;
            cnt_nxt   = byte_count + CNT_W'(1);
            state_nxt = S_RX_ACK;
          end else begin
            state_nxt = S_RX_NACK;
          end
        end
        S_RX_ACK: begin
          if (ack_done)      state_nxt = S_RX_DATA;
          else if (ack_prep) sda_nxt   = 2'd1;
        end
        S_RX_NACK: begin
          if (ack_done)      state_nxt = S_WAIT_STOP;
          else if (ack_prep) sda_nxt   = 2'd2;
        end
        S_TX_LOAD: begin
          ld_nxt    = 1'b1;
          re_nxt    = !tx_fifo_empty;
          un_nxt    = tx_fifo_empty;
          cnt_nxt   = byte_count + CNT_W'(1);
          state_nxt = S_TX_DATA;
        end
        S_TX_DATA: if (ack_prep) state_nxt = S_TX_CHK;
        S_TX_CHK: if (check_ack) state_nxt = sda_in ? S_WAIT_STOP : S_TX_WAIT;
        S_TX_WAIT: if (ack_done) state_nxt = S_TX_LOAD;
        S_WAIT_STOP: state_nxt = S_WAIT_STOP;
        default: state_nxt = S_IDLE;
      endcase
    end
    // Any state change re-derives the SDA select; only TX_DATA enters driving data.
    if (state_nxt != state) sda_nxt = (state_nxt == S_TX_DATA) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rx_enable    <= 1'b0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      load_data    <= 1'b0;
      tx_underrun  <= 1'b0;
      busy         <= 1'b0;
      sda_mode     <= 2'd0;
      byte_count   <= '0;
    end else begin
      state        <= state_nxt;
      rx_enable    <= (state_nxt == S_ADDR) || (state_nxt == S_RX_DATA);
      write_enable <= we_nxt;
      read_enable  <= re_nxt;
      load_data    <= ld_nxt;
      tx_underrun  <= un_nxt;
      busy         <= (state_nxt != S_IDLE);
      sda_mode     <= sda_nxt;
      byte_count   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bus-level driver tasks, an ACK-bit SDA scoreboard and
// a transaction-level model predicting pulse counts and byte_count.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_found = 1'b0, stop_found = 1'b0, address_match = 1'b0, rw_mode = 1'b0;
  logic       byte_received = 1'b0, ack_prep = 1'b0, check_ack = 1'b0, ack_done = 1'b0;
  logic       sda_in = 1'b1, rx_fifo_full = 1'b0, tx_fifo_empty = 1'b0;
  logic       rx_enable, write_enable, read_enable, load_data, tx_underrun, busy;
  logic [1:0] sda_mode;
  logic [7:0] byte_count;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  int n_we = 0, n_re = 0, n_ld = 0, n_un = 0, n_wide = 0;
  logic p_we = 1'b0, p_re = 1'b0, p_ld = 1'b0, p_un = 1'b0;

  localparam int P_START = 0, P_STOP = 1, P_BYTE = 2, P_PREP = 3, P_CHK = 4, P_DONE = 5;

  i2c_slave_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
    .address_match(address_match), .rw_mode(rw_mode), .byte_received(byte_received),
    .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done), .sda_in(sda_in),
    .rx_fifo_full(rx_fifo_full), .tx_fifo_empty(tx_fifo_empty), .rx_enable(rx_enable),
    .write_enable(write_enable), .read_enable(read_enable), .load_data(load_data),
    .sda_mode(sda_mode), .tx_underrun(tx_underrun), .busy(busy), .byte_count(byte_count),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Pulse monitor: counts strobes and flags any strobe wider than one cycle
  always @(negedge clk) begin
    if (write_enable) n_we++;
    if (read_enable)  n_re++;
    if (load_data)    n_ld++;
    if (tx_underrun)  n_un++;
    if ((write_enable && p_we) || (read_enable && p_re) ||
        (load_data && p_ld) || (tx_underrun && p_un)) n_wide++;
    p_we = write_enable; p_re = read_enable; p_ld = load_data; p_un = tx_underrun;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int sel);
    case (sel)
      P_START: start_found   = 1'b1;
      P_STOP:  stop_found    = 1'b1;
      P_BYTE:  byte_received = 1'b1;
      P_PREP:  ack_prep      = 1'b1;
      P_CHK:   check_ack     = 1'b1;
      default: ack_done      = 1'b1;
    endcase
    tick(1);
    start_found = 1'b0; stop_found = 1'b0; byte_received = 1'b0;
    ack_prep = 1'b0; check_ack = 1'b0; ack_done = 1'b0;
  endtask

  task automatic sb_check(input string name);
    logic [1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got sda_mode=%0d", name, sda_mode);
    end else begin
      e = exp_q.pop_front();
      if (sda_mode !== e) begin
        bad++;
        $display("FAIL %s: got sda_mode=%0d expected %0d", name, sda_mode, e);
      end
    end
  endtask

  task automatic drv_addr(input logic match, input logic rw);
    address_match = match; rw_mode = rw;
    pulse(P_START);
    tick(2);
    pulse(P_BYTE);
    tick(2);
    pulse(P_PREP);
    tick(1);
    sb_check("addr_ack_bit");
    pulse(P_CHK);
    pulse(P_DONE);
  endtask

  task automatic drv_wbyte(input logic full);
    tick(2);
    rx_fifo_full = full;
    pulse(P_BYTE);
    tick(1);
    rx_fifo_full = 1'b0;
    tick(1);
    pulse(P_PREP);
    tick(1);
    sb_check("rx_ack_bit");
    pulse(P_CHK);
    pulse(P_DONE);
  endtask

  task automatic drv_rbyte(input logic empty, input logic nack);
    tx_fifo_empty = empty;
    tick(1);
    tx_fifo_empty = 1'b0;
    tick(1);
    sb_check("tx_data_bit");
    tick(1);
    pulse(P_PREP);
    sda_in = nack;
    tick(1);
    pulse(P_CHK);
    sda_in = 1'b1;
    pulse(P_DONE);
  endtask

  // Scenario tasks
  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    total++;
    if ({rx_enable, write_enable, read_enable, load_data, tx_underrun, busy, sda_mode, byte_count} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%0d rx_en=%0d sda=%0d cnt=%0d, expected all 0",
               busy, rx_enable, sda_mode, byte_count);
    end
    pulse(P_START);
    total++;
    if (busy !== 1'b1 || rx_enable !== 1'b1) begin
      bad++;
      $display("FAIL start_to_addr: got busy=%0d rx_en=%0d expected 1 1", busy, rx_enable);
    end
    pulse(P_STOP);
  endtask

  task automatic test_write_one;
    int b_we;
    b_we = n_we;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    drv_addr(1'b1, 1'b0);
    total++;
    if (rx_enable !== 1'b1) begin
      bad++;
      $display("FAIL rx_data_enable: got %0d expected 1", rx_enable);
    end
    drv_wbyte(1'b0);
    total++;
    if (n_we - b_we != 1 || byte_count !== 8'd1) begin
      bad++;
      $display("FAIL write_one: got pushes=%0d cnt=%0d expected 1 1", n_we - b_we, byte_count);
    end
    pulse(P_STOP);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL write_one_stop: got busy=%0d expected 0", busy);
    end
  endtask

  task automatic test_addr_nack;
    int b_we;
    b_we = n_we;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    drv_addr(1'b0, 1'b0);
    drv_wbyte(1'b0);
    for (int i = 0; i < 9; i++) begin
      pulse(P_BYTE);
      tick(1);
    end
    total++;
    if (n_we != b_we || busy !== 1'b1 || rx_enable !== 1'b0) begin
      bad++;
      $display("FAIL addr_nack: got pushes=%0d busy=%0d rx_en=%0d expected 0 1 0",
               n_we - b_we, busy, rx_enable);
    end
    pulse(P_STOP);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL addr_nack_stop: got busy=%0d expected 0", busy);
    end
  endtask

  task automatic test_read3;
    int b_ld, b_re, b_un;
    b_ld = n_ld; b_re = n_re; b_un = n_un;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 3; i++) exp_q.push_back(2'd3);
    drv_addr(1'b1, 1'b1);
    drv_rbyte(1'b0, 1'b0);
    drv_rbyte(1'b0, 1'b0);
    drv_rbyte(1'b0, 1'b1);
    total++;
    if (n_ld - b_ld != 3 || n_re - b_re != 3 || n_un != b_un) begin
      bad++;
      $display("FAIL read3_pulses: got ld=%0d re=%0d un=%0d expected 3 3 0",
               n_ld - b_ld, n_re - b_re, n_un - b_un);
    end
    total++;
    if (byte_count !== 8'd3 || busy !== 1'b1 || sda_mode !== 2'd0) begin
      bad++;
      $display("FAIL read3_state: got cnt=%0d busy=%0d sda=%0d expected 3 1 0",
               byte_count, busy, sda_mode);
    end
    pulse(P_STOP);
  endtask

  task automatic test_rx_full;
    int b_we;
    b_we = n_we;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    drv_addr(1'b1, 1'b0);
    drv_wbyte(1'b0);
    drv_wbyte(1'b1);
    total++;
    if (n_we - b_we != 1 || byte_count !== 8'd1 || rx_enable !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rx_full: got pushes=%0d cnt=%0d rx_en=%0d busy=%0d expected 1 1 0 1",
               n_we - b_we, byte_count, rx_enable, busy);
    end
    pulse(P_STOP);
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    drv_addr(1'b1, 1'b0);
    drv_wbyte(1'b0);
    tick(1);
    pulse(P_START);
    total++;
    if (byte_count !== 8'd0 || rx_enable !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart: got cnt=%0d rx_en=%0d busy=%0d expected 0 1 1",
               byte_count, rx_enable, busy);
    end
    pulse(P_BYTE);
    total++;
    if (rx_enable !== 1'b0) begin
      bad++;
      $display("FAIL restart_addr_byte: got rx_en=%0d expected 0", rx_enable);
    end
    start_found = 1'b1;
    stop_found  = 1'b1;
    tick(1);
    start_found = 1'b0;
    stop_found  = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_stop_same: got busy=%0d expected 0", busy);
    end
  endtask

  task automatic test_underrun_rst;
    int b_re, b_un, b_ld;
    b_re = n_re; b_un = n_un; b_ld = n_ld;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    drv_addr(1'b1, 1'b1);
    drv_rbyte(1'b1, 1'b0);
    total++;
    if (n_un - b_un != 1 || n_ld - b_ld != 1 || n_re != b_re) begin
      bad++;
      $display("FAIL underrun: got un=%0d ld=%0d re=%0d expected 1 1 0",
               n_un - b_un, n_ld - b_ld, n_re - b_re);
    end
    tick(1);
    total++;
    if (load_data !== 1'b1 || sda_mode !== 2'd3) begin
      bad++;
      $display("FAIL second_load: got ld=%0d sda=%0d expected 1 3", load_data, sda_mode);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if ({rx_enable, write_enable, read_enable, load_data, tx_underrun, busy, sda_mode, byte_count} !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_tx: got busy=%0d ld=%0d sda=%0d cnt=%0d expected all 0",
               busy, load_data, sda_mode, byte_count);
    end
  endtask

  // Random transactions checked against a transaction-level model
  task automatic test_random;
    int unsigned n;
    logic match, rw, stopped;
    logic [4:0] fmask, nmask;
    int e_we, e_ld, e_re, e_un, b_we, b_ld, b_re, b_un;
    for (int t = 0; t < 20; t++) begin
      n     = $urandom_range(1, 5);
      match = ($urandom_range(0, 3) != 0);
      rw    = 1'($urandom_range(0, 1));
      fmask = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      nmask = 5'($urandom) & 5'($urandom);
      nmask[n-1] = 1'b1;
      e_we = 0; e_ld = 0; e_re = 0; e_un = 0;
      stopped = !match;
      exp_q.push_back(match ? 2'd1 : 2'd0);
      for (int i = 0; i < int'(n); i++) begin
        if (stopped) begin
          exp_q.push_back(2'd0);
        end else if (!rw) begin
          if (fmask[i]) begin
            exp_q.push_back(2'd2);
            stopped = 1'b1;
          end else begin
            exp_q.push_back(2'd1);
            e_we++;
          end
        end else begin
          exp_q.push_back(2'd3);
          e_ld++;
          if (fmask[i]) e_un++; else e_re++;
          if (nmask[i]) stopped = 1'b1;
        end
      end
      b_we = n_we; b_ld = n_ld; b_re = n_re; b_un = n_un;
      drv_addr(match, rw);
      for (int i = 0; i < int'(n); i++) begin
        if (rw) drv_rbyte(fmask[i], nmask[i]);
        else    drv_wbyte(fmask[i]);
      end
      total++;
      if (n_we - b_we != e_we || n_ld - b_ld != e_ld || n_re - b_re != e_re || n_un - b_un != e_un) begin
        bad++;
        $display("FAIL rand_pulses t=%0d: got we=%0d ld=%0d re=%0d un=%0d expected %0d %0d %0d %0d",
                 t, n_we - b_we, n_ld - b_ld, n_re - b_re, n_un - b_un, e_we, e_ld, e_re, e_un);
      end
      total++;
      if (byte_count !== 8'(e_we + e_ld)) begin
        bad++;
        $display("FAIL rand_count t=%0d: got %0d expected %0d", t, byte_count, e_we + e_ld);
      end
      pulse(P_STOP);
      total++;
      if (busy !== 1'b0 || byte_count !== 8'(e_we + e_ld)) begin
        bad++;
        $display("FAIL rand_stop t=%0d: got busy=%0d cnt=%0d expected 0 %0d",
                 t, busy, byte_count, e_we + e_ld);
      end
    end
  endtask

  task automatic test_final;
    total++;
    if (n_wide != 0) begin
      bad++;
      $display("FAIL pulse_width: got %0d wide pulses expected 0", n_wide);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_one();
    test_addr_nack();
    test_read3();
    test_rx_full();
    test_back_to_back();
    test_underrun_rst();
    test_random();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
